rv32imf_data_obi_arbiter: RTL and testbench
===========================================

// Module: rv32imf_data_obi_arbiter
// PURPOSE
//  Shares the single data-side OBI port between two masters: m0 = load/store unit, m1 = debug/aux access.
//  Sits between the LSU OBI interface and the data memory bus.
//  Arbitrates requests and holds the selection stable until grant (OBI address-phase rule).
//  Records the owner of each granted transaction in order and routes each response back to that owner.
// PARAMETERS
//  MAX_OUTSTANDING  2  granted-but-unanswered transactions allowed on the slave port (1..4)
//  FIXED_PRIO       0  0 = round-robin between m0/m1; 1 = m0 always wins a tie
// PORTS
//  clk         in   1     clock
//  rst_n       in   1     asynchronous reset, active low
//  m_req_i     in   2     per-master request
//  m_gnt_o     out  2     per-master grant
//  m_addr_i    in   2x32  per-master address
//  m_we_i      in   2     per-master write enable
//  m_be_i      in   2x4   per-master byte enable
//  m_wdata_i   in   2x32  per-master write data
//  m_atop_i    in   2x6   per-master atomic op
//  m_rvalid_o  out  2     per-master response valid
//  m_rdata_o   out  32    response read data, shared by both masters
//  m_err_o     out  1     response error, shared; qualified by m_rvalid_o
//  s_req_o     out  1     slave request
//  s_gnt_i     in   1     slave grant
//  s_addr_o    out  32    slave address
//  s_we_o      out  1     slave write enable
//  s_be_o      out  4     slave byte enable
//  s_wdata_o   out  32    slave write data
//  s_atop_o    out  6     slave atomic op
//  s_rvalid_i  in   1     slave response valid
//  s_rdata_i   in   32    slave read data
//  s_err_i     in   1     slave response error
//  busy_o      out  1     high when count != 0 or s_req_o is high
// BEHAVIOUR
//  Reset: lock_q=0, sel_q=0, rr_last_q=1 (m0 wins first tie), ID FIFO empty, count=0.
//    Consequence: s_req_o=0 and m_gnt_o=0 while no m_req_i; m_rvalid_o=0; busy_o=0.
//  full = (count == MAX_OUTSTANDING).
//    While full: s_req_o=0 and m_gnt_o=0.
//    No bypass: a response in the same cycle does not unblock issue until the next cycle.
//  Selection sel:
//    lock_q=1 -> sel=sel_q.
//    Otherwise, single requester -> that master.
//    Otherwise, both requesting -> FIXED_PRIO ? m0 : ~rr_last_q.
//  Slave request: s_req_o = m_req_i[sel] & ~full; s_addr/we/be/wdata/atop = m_*[sel].
//    Combinational, zero-cycle path.
//  Grant: m_gnt_o[sel] = s_gnt_i & s_req_o; the other bit is 0. Combinational.
//  Lock: s_req_o & ~s_gnt_i -> lock_q<=1, sel_q<=sel.
//    Handshake -> lock_q<=0, rr_last_q<=sel.
//    Locked master drops req (protocol violation) -> lock_q<=0; SVA flags it.
//  On handshake (s_req_o & s_gnt_i): push sel into ID FIFO, count+1.
//  On s_rvalid_i with FIFO non-empty:
//    m_rvalid_o[head]=1 in the same cycle; pop; count-1.
//    m_rdata_o=s_rdata_i and m_err_o=s_err_i unconditionally.
//  Push and pop in the same cycle: count unchanged; both pointers advance; pointers wrap modulo depth.
//  s_rvalid_i with FIFO empty: ignored, no m_rvalid_o, count stays 0; SVA flags it.
//  Reset mid-transaction: all state cleared; late slave responses are dropped by the empty-FIFO rule.
//  No response reordering: responses are returned strictly in grant order.
// STRUCTURE
//  rv32imf_pkg: add obi_req_t {addr[31:0], we, be[3:0], wdata[31:0], atop[5:0]} and obi_rsp_t {rdata[31:0], err}.
//  Sub-module rv32imf_obi_id_fifo: sync FIFO, width 1, depth MAX_OUTSTANDING, push/pop/head/empty/full/count.
//    Async reset; wrap-around pointers.
//  Top level keeps the arbitration/lock flops and the request/response muxes.
// TESTING
//  1. m0 req addr=0x1000, gnt same cycle, rvalid 2 cycles later with rdata=0xDEADBEEF
//     -> m_gnt_o=01; m_rvalid_o=01 with rdata=0xDEADBEEF; count 0->1->0.
//  2. Both req, RR, gnt always 1
//     -> grants alternate m0,m1,m0,m1; FIXED_PRIO=1 -> m0 every cycle while it requests.
//  3. m1 req, gnt held low 3 cycles while m0 raises req
//     -> s_addr_o stays m1 address, m_gnt_o=10 on cycle 4, then m0 is served.
//  4. Two grants (m0 then m1), no rvalid
//     -> third req blocked (s_req_o=0); rvalid pops m0, next cycle issue resumes; second rvalid goes to m1.
//  5. Push and pop in the same cycle at count=1 -> count stays 1, correct owner routed; exercise FIFO wrap 8 times.
//  6. rst_n low with 2 outstanding, then stray s_rvalid_i -> no m_rvalid_o, busy_o=0, s_req_o=0 without m_req_i.

Source files
------------

// File: rtl/rv32imf_pkg.sv
// Shared types for the rv32imf data-side OBI path: request/response payloads and sizing helpers.
package rv32imf_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [5:0]  atop;
   } obi_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } obi_rsp_t;

   localparam int unsigned OBI_NUM_MASTERS = 2;

   // Bits needed to hold a value in 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/rv32imf_obi_id_fifo.sv
// Owner-ID FIFO for outstanding OBI transactions; 1-bit entries, registered state, head visible same cycle.
// Push is ignored when full and pop when empty; the caller guarantees neither happens in normal use.
module rv32imf_obi_id_fifo
   import rv32imf_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CW    = cnt_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          push_dat_i,
   input  logic          pop_i,
   output logic          head_o,
   output logic          empty_o,
   output logic          full_o,
   output logic [CW-1:0] count_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] r_mem;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty_o = (r_count == '0);
   assign full_o  = (r_count == CW'(DEPTH));
   assign count_o = r_count;
   assign head_o  = r_mem[r_rd_ptr];
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= push_dat_i;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/rv32imf_data_obi_arbiter.sv
// Two-master OBI data-port arbiter: zero-cycle request/grant path, selection held until grant.
// Issue stalls when MAX_OUTSTANDING transactions are in flight; responses return in grant order.
module rv32imf_data_obi_arbiter
   import rv32imf_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter bit          FIXED_PRIO      = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       m_req_i,
   output logic [1:0]       m_gnt_o,
   input  logic [1:0][31:0] m_addr_i,
   input  logic [1:0]       m_we_i,
   input  logic [1:0][3:0]  m_be_i,
   input  logic [1:0][31:0] m_wdata_i,
   input  logic [1:0][5:0]  m_atop_i,
   output logic [1:0]       m_rvalid_o,
   output logic [31:0]      m_rdata_o,
   output logic             m_err_o,
   output logic             s_req_o,
   input  logic             s_gnt_i,
   output logic [31:0]      s_addr_o,
   output logic             s_we_o,
   output logic [3:0]       s_be_o,
   output logic [31:0]      s_wdata_o,
   output logic [5:0]       s_atop_o,
   input  logic             s_rvalid_i,
   input  logic [31:0]      s_rdata_i,
   input  logic             s_err_i,
   output logic             busy_o
);

   localparam int unsigned CW = cnt_width(MAX_OUTSTANDING);

   logic                                r_lock;
   logic                                r_sel;
   logic                                r_rr_last;
   obi_req_t [OBI_NUM_MASTERS-1:0]      w_mreq;
   obi_req_t                            w_sel_req;
   obi_rsp_t                            w_rsp;
   logic                                w_sel;
   logic                                w_sreq;
   logic                                w_hs;
   logic                                w_pop;
   logic                                w_head;
   logic                                w_empty;
   logic                                w_full;
   logic [CW-1:0]                       w_count;

   always_comb begin
      for (int i = 0; i < OBI_NUM_MASTERS; i++) begin
         w_mreq[i] = '{addr:  m_addr_i[i],
                       we:    m_we_i[i],
                       be:    m_be_i[i],
                       wdata: m_wdata_i[i],
                       atop:  m_atop_i[i]};
      end
   end

   // A stalled address phase keeps its master until granted, whatever the other side does.
   always_comb begin
      w_sel = 1'b0;
      if (r_lock) begin
         w_sel = r_sel;
      end else begin
         case (m_req_i)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
            2'b11:   w_sel = FIXED_PRIO ? 1'b0 : ~r_rr_last;
            default: w_sel = 1'b0;
         endcase
      end
   end

   assign w_sreq    = m_req_i[w_sel] & ~w_full;
   assign w_hs      = w_sreq & s_gnt_i;
   assign w_sel_req = w_mreq[w_sel];

   assign s_req_o   = w_sreq;
   assign s_addr_o  = w_sel_req.addr;
   assign s_we_o    = w_sel_req.we;
   assign s_be_o    = w_sel_req.be;
   assign s_wdata_o = w_sel_req.wdata;
   assign s_atop_o  = w_sel_req.atop;
   assign m_gnt_o   = w_hs ? (w_sel ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock    <= 1'b0;
         r_sel     <= 1'b0;
         r_rr_last <= 1'b1;
      end else begin
         if (w_sreq && !s_gnt_i) begin
            r_lock <= 1'b1;
            r_sel  <= w_sel;
         end else if (w_hs) begin
            r_lock    <= 1'b0;
            r_rr_last <= w_sel;
         end else if (r_lock && !m_req_i[r_sel]) begin
            r_lock <= 1'b0;
         end
      end
   end

   rv32imf_obi_id_fifo #(
      .DEPTH      (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (w_hs),
      .push_dat_i (w_sel),
      .pop_i      (w_pop),
      .head_o     (w_head),
      .empty_o    (w_empty),
      .full_o     (w_full),
      .count_o    (w_count)
   );

   // Responses with nothing outstanding (e.g. late ones after reset) are dropped here.
   assign w_pop      = s_rvalid_i & ~w_empty;
   assign m_rvalid_o = w_pop ? (w_head ? 2'b10 : 2'b01) : 2'b00;
   assign w_rsp      = '{rdata: s_rdata_i, err: s_err_i};
   assign m_rdata_o  = w_rsp.rdata;
   assign m_err_o    = w_rsp.err;
   assign busy_o     = (w_count != '0) | w_sreq;

   a_lock_hold: assert property (@(posedge clk) disable iff (!rst_n)
      !(r_lock && !m_req_i[r_sel]))
      else $error("locked master withdrew its request before grant");

   c_stray_rsp: cover property (@(posedge clk) disable iff (!rst_n)
      s_rvalid_i && w_empty);

endmodule

// File: tb/tb_rv32imf_data_obi_arbiter.sv
// Scoreboarded bench for the two-master OBI data arbiter (round-robin and fixed-priority instances).
module tb_rv32imf_data_obi_arbiter;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       m_req;
   logic [1:0][31:0] m_addr;
   logic [1:0]       m_we;
   logic [1:0][3:0]  m_be;
   logic [1:0][31:0] m_wdata;
   logic [1:0][5:0]  m_atop;
   logic             s_gnt;
   logic             s_rvalid;
   logic [31:0]      s_rdata;
   logic             s_err;

   logic [1:0]       m_gnt, m_rvalid;
   logic [31:0]      m_rdata, s_addr, s_wdata;
   logic             m_err, s_req, s_we, busy;
   logic [3:0]       s_be;
   logic [5:0]       s_atop;

   logic             fp_en;
   logic [1:0]       fp_req;
   logic             fp_rvalid_in;
   logic [1:0]       fp_gnt, fp_rvalid;
   logic [31:0]      fp_rdata, fp_addr, fp_wdata;
   logic             fp_err, fp_sreq, fp_we, fp_busy;
   logic [3:0]       fp_be;
   logic [5:0]       fp_atop;

   int               n_chk  = 0;
   int               n_fail = 0;
   bit               sb_q[$];

   assign fp_req       = m_req & {2{fp_en}};
   assign fp_rvalid_in = s_rvalid & fp_en;

   always #5 clk = ~clk;

   rv32imf_data_obi_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
      .m_be_i(m_be), .m_wdata_i(m_wdata), .m_atop_i(m_atop),
      .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .m_err_o(m_err),
      .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we),
      .s_be_o(s_be), .s_wdata_o(s_wdata), .s_atop_o(s_atop),
      .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_err_i(s_err),
      .busy_o(busy)
   );

   rv32imf_data_obi_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1'b1)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .m_req_i(fp_req), .m_gnt_o(fp_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
      .m_be_i(m_be), .m_wdata_i(m_wdata), .m_atop_i(m_atop),
      .m_rvalid_o(fp_rvalid), .m_rdata_o(fp_rdata), .m_err_o(fp_err),
      .s_req_o(fp_sreq), .s_gnt_i(s_gnt), .s_addr_o(fp_addr), .s_we_o(fp_we),
      .s_be_o(fp_be), .s_wdata_o(fp_wdata), .s_atop_o(fp_atop),
      .s_rvalid_i(fp_rvalid_in), .s_rdata_i(s_rdata), .s_err_i(s_err),
      .busy_o(fp_busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // One clock of stimulus; combinational outputs are sampled mid-cycle.
   task automatic drive_cycle(input logic [1:0] req, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic exp_sreq,
                              input logic exp_sel, input logic [1:0] exp_fp,
                              input string tag);
      logic [1:0] exp_gnt;
      bit         own;
      m_req    = req;
      s_gnt    = gnt;
      s_rvalid = rv;
      s_rdata  = rdata;
      s_err    = rdata[0];
      #4;
      chk({tag, ".s_req"}, 32'(s_req), 32'(exp_sreq));
      if (exp_sreq) begin
         chk({tag, ".s_addr"},  s_addr,         m_addr[exp_sel]);
         chk({tag, ".s_wdata"}, s_wdata,        m_wdata[exp_sel]);
         chk({tag, ".s_we"},    32'(s_we),      32'(m_we[exp_sel]));
         chk({tag, ".s_be"},    32'(s_be),      32'(m_be[exp_sel]));
         chk({tag, ".s_atop"},  32'(s_atop),    32'(m_atop[exp_sel]));
      end
      exp_gnt = (exp_sreq && gnt) ? (exp_sel ? 2'b10 : 2'b01) : 2'b00;
      chk({tag, ".m_gnt"}, 32'(m_gnt), 32'(exp_gnt));
      if (rv && sb_q.size() > 0) begin
         own = sb_q.pop_front();
         chk({tag, ".m_rvalid"}, 32'(m_rvalid), own ? 32'd2 : 32'd1);
         chk({tag, ".m_rdata"},  m_rdata,       rdata);
         chk({tag, ".m_err"},    32'(m_err),    32'(rdata[0]));
      end else begin
         chk({tag, ".m_rvalid_idle"}, 32'(m_rvalid), 32'd0);
      end
      if (exp_gnt != 2'b00) sb_q.push_back(exp_sel);
      if (fp_en) begin
         chk({tag, ".fp_gnt"},    32'(fp_gnt),    32'(exp_fp));
         chk({tag, ".fp_rvalid"}, 32'(fp_rvalid), rv ? 32'd1 : 32'd0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      m_addr[0]  = 32'h0000_1000;  m_addr[1]  = 32'h0000_2000;
      m_wdata[0] = 32'hA0A0_0000;  m_wdata[1] = 32'hB1B1_1111;
      m_we       = 2'b10;
      m_be[0]    = 4'hF;           m_be[1]    = 4'h3;
      m_atop[0]  = 6'h00;          m_atop[1]  = 6'h21;
      rst_n = 1'b0; fp_en = 1'b0; m_req = 2'b00; s_gnt = 1'b0;
      s_rvalid = 1'b0; s_rdata = '0; s_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.s_req",  32'(s_req),       32'd0);
      chk("rst.m_gnt",  32'(m_gnt),       32'd0);
      chk("rst.rvalid", 32'(m_rvalid),    32'd0);
      chk("rst.busy",   32'(busy),        32'd0);
      chk("rst.count",  32'(dut.w_count), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single m0 read, response two cycles after grant.
      drive_cycle(2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, "t1_req");
      chk("t1.count1", 32'(dut.w_count), 32'd1);
      chk("t1.busy1",  32'(busy),        32'd1);
      drive_cycle(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, "t1_wait");
      drive_cycle(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'b00, "t1_rsp");
      chk("t1.count0", 32'(dut.w_count), 32'd0);
      chk("t1.busy0",  32'(busy),        32'd0);

      // Continuous contention: RR alternates (m0 won last), FIXED_PRIO always m0.
      // Steady push+pop at count 1 walks the depth-2 pointers around eight times.
      fp_en = 1'b1;
      for (int k = 0; k < 17; k++) begin
         if (k > 0) chk("t2.count", 32'(dut.w_count), 32'd1);
         drive_cycle(2'b11, 1'b1, (k > 0), 32'h5000_0000 + 32'(k), 1'b1,
                     (k % 2 == 0), 2'b01, "t2_rr");
      end
      drive_cycle(2'b00, 1'b0, 1'b1, 32'h5555_0001, 1'b0, 1'b0, 2'b00, "t2_drain");
      fp_en = 1'b0;
      chk("t2.count0",    32'(dut.w_count),    32'd0);
      chk("t2.fp_count0", 32'(dut_fp.w_count), 32'd0);

      // m1 stalled three cycles while m0 joins; selection must not move.
      drive_cycle(2'b10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, "t3_wait0");
      drive_cycle(2'b11, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, "t3_wait1");
      drive_cycle(2'b11, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, "t3_wait2");
      drive_cycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, "t3_gnt");
      drive_cycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, "t3_m0");
      drive_cycle(2'b00, 1'b0, 1'b1, 32'h3333_0001, 1'b0, 1'b0, 2'b00, "t3_rsp1");
      drive_cycle(2'b00, 1'b0, 1'b1, 32'h3333_0002, 1'b0, 1'b0, 2'b00, "t3_rsp0");

      // Outstanding limit: full blocks issue, and a pop does not bypass into the same cycle.
      drive_cycle(2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, "t4_g0");
      drive_cycle(2'b10, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, "t4_g1");
      drive_cycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, "t4_full");
      chk("t4.busy_full", 32'(busy), 32'd1);
      drive_cycle(2'b11, 1'b1, 1'b1, 32'h4444_0000, 1'b0, 1'b0, 2'b00, "t4_pop");
      drive_cycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, "t4_resume");
      drive_cycle(2'b00, 1'b0, 1'b1, 32'h4444_0001, 1'b0, 1'b0, 2'b00, "t4_rsp1");
      drive_cycle(2'b00, 1'b0, 1'b1, 32'h4444_0002, 1'b0, 1'b0, 2'b00, "t4_rsp2");
      chk("t4.count0", 32'(dut.w_count), 32'd0);

      // Reset with two in flight, then a late response that must be dropped.
      drive_cycle(2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, "t6_g0");
      drive_cycle(2'b10, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, "t6_g1");
      chk("t6.count2", 32'(dut.w_count), 32'd2);
      m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b0;
      rst_n = 1'b0;
      #4;
      chk("t6.rst_busy",  32'(busy),        32'd0);
      chk("t6.rst_sreq",  32'(s_req),       32'd0);
      chk("t6.rst_count", 32'(dut.w_count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb_q.delete();
      drive_cycle(2'b00, 1'b0, 1'b1, 32'h6666_0001, 1'b0, 1'b0, 2'b00, "t6_stray");
      chk("t6.count0", 32'(dut.w_count), 32'd0);
      chk("t6.busy0",  32'(busy),        32'd0);
      drive_cycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, "t6_rr_reset");
      drive_cycle(2'b00, 1'b0, 1'b1, 32'h6666_0002, 1'b0, 1'b0, 2'b00, "t6_rsp");
      chk("t6.final_count", 32'(dut.w_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
